// File: rtl/c64_pkg.sv
// Shared C64 constants: CPU port addresses and port bit roles.
// Also holds the small read-back helper used by the port mux.
package c64_pkg;

   localparam logic [15:0] CPU_PORT_DDR_ADDR  = 16'h0000;
   localparam logic [15:0] CPU_PORT_DATA_ADDR = 16'h0001;

   localparam int PORT_LORAM     = 0;
   localparam int PORT_HIRAM     = 1;
   localparam int PORT_CHAREN    = 2;
   localparam int PORT_CAS_WR    = 3;
   localparam int PORT_CAS_SENSE = 4;
   localparam int PORT_CAS_MOTOR = 5;
   localparam int PORT_FADE_LO   = 6;
   localparam int PORT_FADE_HI   = 7;

   // Level seen on a port pin: driven value when an output,
   // otherwise whatever keeps the pin when undriven.
   function automatic logic pin_level(
      input logic oe,
      input logic drv,
      input logic idle
   );
      return oe ? drv : idle;
   endfunction

endpackage

// File: rtl/cpu_port_if.sv
// CPU core bus as seen by the 6510 on-chip I/O port.
// master = CPU core side, slave = port side.
interface cpu_port_if;
   logic        ce;
   logic [15:0] A;
   logic        R__W;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        dout_en;

   modport master (
      output ce, A, R__W, din,
      input  dout, dout_en
   );

   modport slave (
      input  ce, A, R__W, din,
      output dout, dout_en
   );
endinterface

// File: rtl/cpu_port_fade.sv
// Charge/decay model of one undriven port bit (6 or 7).
// A retained 1 bleeds to 0 after FADE_CYCLES ce cycles.
module cpu_port_fade #(
   parameter int FADE_CYCLES = 350000,
   parameter int FADE_W      = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic ce,
   input  logic ddr_cur,
   input  logic ddr_nxt,
   input  logic data_nxt,
   input  logic wr_data,
   output logic fade
);

   localparam logic [FADE_W-1:0] LAST = FADE_W'(FADE_CYCLES - 1);

   logic [FADE_W-1:0] cnt;
   logic              charge;

   // Driving the bit, rewriting it, or releasing it all reload the
   // latch with the level the pin carries after this cycle's write.
   assign charge = ddr_nxt | wr_data | (ddr_cur & ~ddr_nxt);

   // Latch follows charge events, otherwise decays while it holds a 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fade <= 1'b0;
         cnt  <= '0;
      end else if (ce) begin
         if (charge) begin
            fade <= data_nxt;
            cnt  <= '0;
         end else if (fade) begin
            if (cnt == LAST) begin
               fade <= 1'b0;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/cpu_port.sv
// 6510 on-chip I/O port: DDR at $0000, data at $0001.
// Drives the PLA banking lines and cassette pins.
module cpu_port
   import c64_pkg::*;
#(
   parameter int FADE_CYCLES = 350000,
   parameter int FADE_W      = 20
) (
   input  logic           clk,
   input  logic           reset,
   cpu_port_if.slave      bus,
   input  logic [7:0]     pins_in,
   output logic [7:0]     port_out,
   output logic [7:0]     port_oe,
   output logic           _LORAM,
   output logic           _HIRAM,
   output logic           _CHAREN
);

   logic [7:0] ddr;
   logic [7:0] data;
   logic [7:0] ddr_nxt;
   logic [7:0] data_nxt;
   logic [7:0] rd_val;
   logic [7:6] fade;
   logic       hit_ddr;
   logic       hit_data;
   logic       wr_ddr;
   logic       wr_data;
   logic       unused_pins;

   assign hit_ddr  = (bus.A == CPU_PORT_DDR_ADDR);
   assign hit_data = (bus.A == CPU_PORT_DATA_ADDR);
   assign wr_ddr   = bus.ce & ~bus.R__W & hit_ddr;
   assign wr_data  = bus.ce & ~bus.R__W & hit_data;

   assign ddr_nxt  = wr_ddr  ? bus.din : ddr;
   assign data_nxt = wr_data ? bus.din : data;

   // Port registers load straight from the CPU write data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ddr  <= 8'h00;
         data <= 8'h00;
      end else if (bus.ce) begin
         if (wr_ddr) begin
            ddr <= bus.din;
         end
         if (wr_data) begin
            data <= bus.din;
         end
      end
   end

   for (genvar b = PORT_FADE_LO; b <= PORT_FADE_HI; b++) begin : g_fade
      cpu_port_fade #(
         .FADE_CYCLES (FADE_CYCLES),
         .FADE_W      (FADE_W)
      ) u_fade (
         .clk      (clk),
         .reset    (reset),
         .ce       (bus.ce),
         .ddr_cur  (ddr[b]),
         .ddr_nxt  (ddr_nxt[b]),
         .data_nxt (data_nxt[b]),
         .wr_data  (wr_data),
         .fade     (fade[b])
      );
   end

   // Per-bit read-back of $0001: pull-ups, cassette pins, fading bits.
   always_comb begin
      rd_val = 8'h00;
      if (hit_ddr) begin
         rd_val = ddr;
      end else begin
         for (int i = 0; i < 3; i++) begin
            rd_val[i] = pin_level(ddr[i], data[i], 1'b1);
         end
         for (int i = 3; i < 6; i++) begin
            rd_val[i] = pin_level(ddr[i], data[i], pins_in[i]);
         end
         for (int i = 6; i < 8; i++) begin
            rd_val[i] = pin_level(ddr[i], data[i], fade[i]);
         end
      end
   end

   assign bus.dout_en = bus.R__W & (hit_ddr | hit_data);
   assign bus.dout    = bus.dout_en ? rd_val : 8'h00;

   assign port_out = data;
   assign port_oe  = ddr;

   assign _LORAM  = pin_level(ddr[PORT_LORAM],  data[PORT_LORAM],  1'b1);
   assign _HIRAM  = pin_level(ddr[PORT_HIRAM],  data[PORT_HIRAM],  1'b1);
   assign _CHAREN = pin_level(ddr[PORT_CHAREN], data[PORT_CHAREN], 1'b1);

   assign unused_pins = ^{pins_in[7:6], pins_in[2:0]};

endmodule
